mem_arbiter: RTL and testbench

//  Shares the single external main-memory port (27-bit word address, 32-bit data, byte

---
 rtl/mem_arbiter_if.sv | 40 ++++
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of requester, main-memory and status signals around mem_arbiter.
// The arbiter uses the master view; requesters and memory use the slave view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 27
);
  logic              i_req;
  logic [ADDR_W-1:0] i_adr;
  logic [31:0]       i_rdata;
  logic              i_ack;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_adr;
  logic [31:0]       d_wdata;
  logic [3:0]        d_byteen;
  logic [31:0]       d_rdata;
  logic              d_ack;

  logic [ADDR_W-1:0] mem_adr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_byteen;
  logic              mem_rwb;
  logic              mem_en;
  logic [31:0]       mem_rdata;
  logic              mem_done;

  logic              err;

  modport master (
    input  i_req, i_adr, d_req, d_we, d_adr, d_wdata, d_byteen, mem_rdata, mem_done,
    output i_rdata, i_ack, d_rdata, d_ack, mem_adr, mem_wdata, mem_byteen, mem_rwb,
           mem_en, err
  );

  modport slave (
    output i_req, i_adr, d_req, d_we, d_adr, d_wdata, d_byteen, mem_rdata, mem_done,
    input  i_rdata, i_ack, d_rdata, d_ack, mem_adr, mem_wdata, mem_byteen, mem_rwb,
           mem_en, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one main-memory port,
// one transaction at a time, with a one-cycle ack and a hung-transaction abort.
module mem_arbiter #(
  parameter int ADDR_W    = 27,
  parameter int TIMEOUT   = 255,
  parameter int DATA_PRIO = 0
) (
  input logic           ph1,
  input logic           reset,
  mem_arbiter_if.master bus
);

  localparam logic [ADDR_W-1:0] ADR_ZERO   = '0;
  localparam logic [7:0]        LAST_COUNT = 8'(TIMEOUT - 1);
  localparam logic [31:0]       ABORT_DATA = 32'hDEADBEEF;
  localparam logic              PRIO_DATA  = (DATA_PRIO != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] count;
  logic       last_data;
  logic       win_data;
  logic       any_req;
  logic       pick_data;
  logic       finish_ok;
  logic       abort;

  always_ff @(posedge ph1) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // On a tie without fixed priority, the side that did not win last time goes next.
  always_comb begin
    any_req    = bus.i_req | bus.d_req;
    pick_data  = bus.d_req & (~bus.i_req | PRIO_DATA | ~last_data);
    finish_ok  = 1'b0;
    abort      = 1'b0;
    state_next = state;
    case (state)
      IDLE: if (any_req) state_next = BUSY;
      BUSY: begin
        if (bus.mem_done) begin
          finish_ok  = 1'b1;
          state_next = RESP;
        end else if (count == LAST_COUNT) begin
          abort      = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ph1) begin
    if (reset) begin
      bus.mem_adr    <= ADR_ZERO;
      bus.mem_wdata  <= 32'h0;
      bus.mem_byteen <= 4'h0;
      bus.mem_rwb    <= 1'b1;
      bus.mem_en     <= 1'b0;
      bus.i_rdata    <= 32'h0;
      bus.d_rdata    <= 32'h0;
      bus.i_ack      <= 1'b0;
      bus.d_ack      <= 1'b0;
      bus.err        <= 1'b0;
      count          <= 8'd0;
      last_data      <= 1'b0;
      win_data       <= 1'b0;
    end else begin
      bus.i_ack <= 1'b0;
      bus.d_ack <= 1'b0;
      bus.err   <= 1'b0;
      if (state == IDLE && any_req) begin
        bus.mem_en <= 1'b1;
        count      <= 8'd0;
        win_data   <= pick_data;
        last_data  <= pick_data;
        if (pick_data) begin
          bus.mem_adr    <= bus.d_adr;
          bus.mem_wdata  <= bus.d_wdata;
          bus.mem_rwb    <= ~bus.d_we;
          bus.mem_byteen <= bus.d_we ? bus.d_byteen : 4'hF;
        end else begin
          bus.mem_adr    <= bus.i_adr;
          bus.mem_wdata  <= 32'h0;
          bus.mem_rwb    <= 1'b1;
          bus.mem_byteen <= 4'hF;
        end
      end
      // Writes complete without touching the requester's read-data register.
      if (finish_ok) begin
        bus.mem_en <= 1'b0;
        if (win_data) begin
          bus.d_ack <= 1'b1;
          if (bus.mem_rwb) bus.d_rdata <= bus.mem_rdata;
        end else begin
          bus.i_ack <= 1'b1;
          if (bus.mem_rwb) bus.i_rdata <= bus.mem_rdata;
        end
      end else if (abort) begin
        bus.mem_en <= 1'b0;
        bus.err    <= 1'b1;
        if (win_data) begin
          bus.d_ack   <= 1'b1;
          bus.d_rdata <= ABORT_DATA;
        end else begin
          bus.i_ack   <= 1'b1;
          bus.i_rdata <= ABORT_DATA;
        end
      end else if (state == BUSY) begin
        count <= count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a round-robin instance and a data-priority
// instance share all stimulus; a transaction-level model predicts every result.
module tb_mem_arbiter;

  localparam int TMO = 8;

  typedef struct {
    logic        en_start;
    logic [26:0] adr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        rwb;
    logic        stable;
    int          busy;
    logic        hung;
    logic        i_ack;
    logic        d_ack;
    logic        err;
    logic [31:0] i_rdata;
    logic [31:0] d_rdata;
    logic        b_i_ack;
    logic        b_d_ack;
    logic        ack_after;
    int          ack_cycle;
  } obs_t;

  logic        ph1 = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we, mem_done;
  logic [26:0] i_adr, d_adr;
  logic [31:0] d_wdata, mem_rdata;
  logic [3:0]  d_byteen;
  int          cycle = 0;
  int          n_compared = 0;
  int          n_mismatched = 0;

  logic        m_last_data;
  logic [31:0] m_i_rdata, m_d_rdata;

  mem_arbiter_if #(.ADDR_W(27)) bus_a ();
  mem_arbiter_if #(.ADDR_W(27)) bus_b ();

  mem_arbiter #(.ADDR_W(27), .TIMEOUT(TMO), .DATA_PRIO(0)) dut_a (
    .ph1(ph1), .reset(reset), .bus(bus_a.master)
  );
  mem_arbiter #(.ADDR_W(27), .TIMEOUT(TMO), .DATA_PRIO(1)) dut_b (
    .ph1(ph1), .reset(reset), .bus(bus_b.master)
  );

  assign bus_a.i_req = i_req;       assign bus_b.i_req = i_req;
  assign bus_a.i_adr = i_adr;       assign bus_b.i_adr = i_adr;
  assign bus_a.d_req = d_req;       assign bus_b.d_req = d_req;
  assign bus_a.d_we = d_we;         assign bus_b.d_we = d_we;
  assign bus_a.d_adr = d_adr;       assign bus_b.d_adr = d_adr;
  assign bus_a.d_wdata = d_wdata;   assign bus_b.d_wdata = d_wdata;
  assign bus_a.d_byteen = d_byteen; assign bus_b.d_byteen = d_byteen;
  assign bus_a.mem_rdata = mem_rdata; assign bus_b.mem_rdata = mem_rdata;
  assign bus_a.mem_done = mem_done; assign bus_b.mem_done = mem_done;

  always #5 ph1 = ~ph1;
  always @(posedge ph1) cycle <= cycle + 1;

  task automatic tick();
    @(posedge ph1);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    m_last_data = 1'b0;
    m_i_rdata   = 32'h0;
    m_d_rdata   = 32'h0;
  endtask

  // Runs one transaction from an IDLE cycle; mem_done is raised in BUSY cycle
  // done_at (0 = never). Returns in the IDLE cycle that follows the ack.
  task automatic run_txn(input int done_at, input logic [31:0] rdv, output obs_t o);
    int b;
    tick();
    o.en_start = bus_a.mem_en;
    o.adr      = bus_a.mem_adr;
    o.wdata    = bus_a.mem_wdata;
    o.be       = bus_a.mem_byteen;
    o.rwb      = bus_a.mem_rwb;
    o.stable   = 1'b1;
    b = 0;
    while (bus_a.mem_en === 1'b1 && b < 300) begin
      b++;
      mem_done  = (b == done_at);
      mem_rdata = rdv;
      @(negedge ph1);
      if (bus_a.mem_adr !== o.adr || bus_a.mem_wdata !== o.wdata ||
          bus_a.mem_byteen !== o.be || bus_a.mem_rwb !== o.rwb) o.stable = 1'b0;
      tick();
    end
    mem_done    = 1'b0;
    o.busy      = b;
    o.hung      = (b >= 300);
    o.i_ack     = bus_a.i_ack;
    o.d_ack     = bus_a.d_ack;
    o.err       = bus_a.err;
    o.i_rdata   = bus_a.i_rdata;
    o.d_rdata   = bus_a.d_rdata;
    o.b_i_ack   = bus_b.i_ack;
    o.b_d_ack   = bus_b.d_ack;
    o.ack_cycle = cycle;
    tick();
    o.ack_after = bus_a.i_ack | bus_a.d_ack | bus_a.err;
  endtask

  task automatic test_reset();
    reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_done = 1'b0;
    i_adr = '0; d_adr = '0; d_wdata = '0; d_byteen = '0; mem_rdata = '0;
    repeat (3) tick();
    @(negedge ph1);
    n_compared++;
    if ({bus_a.mem_en, bus_a.mem_rwb, bus_a.i_ack, bus_a.d_ack, bus_a.err} !== 5'b01000) begin
      n_mismatched++;
      $display("[TB] FAIL reset_flags: got %b expected 01000",
               {bus_a.mem_en, bus_a.mem_rwb, bus_a.i_ack, bus_a.d_ack, bus_a.err});
    end
    n_compared++;
    if (bus_a.mem_adr !== 27'h0 || bus_a.mem_wdata !== 32'h0 || bus_a.mem_byteen !== 4'h0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_mem_regs: got adr=%h wdata=%h be=%h expected all zero",
               bus_a.mem_adr, bus_a.mem_wdata, bus_a.mem_byteen);
    end
    n_compared++;
    if (bus_a.i_rdata !== 32'h0 || bus_a.d_rdata !== 32'h0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_rdata: got i=%h d=%h expected 0", bus_a.i_rdata, bus_a.d_rdata);
    end
    reset = 1'b0;
    m_last_data = 1'b0; m_i_rdata = 32'h0; m_d_rdata = 32'h0;
    tick();
    mem_done = 1'b1;
    repeat (2) begin
      tick();
      n_compared++;
      if ({bus_a.mem_en, bus_a.i_ack, bus_a.d_ack, bus_a.err} !== 4'b0000) begin
        n_mismatched++;
        $display("[TB] FAIL idle_done_ignored: got %b expected 0000",
                 {bus_a.mem_en, bus_a.i_ack, bus_a.d_ack, bus_a.err});
      end
    end
    mem_done = 1'b0;
  endtask

  task automatic test_instr_read();
    obs_t o;
    i_req = 1'b1; i_adr = 27'h40;
    run_txn(2, 32'h8C010004, o);
    i_req = 1'b0;
    m_last_data = 1'b0; m_i_rdata = 32'h8C010004;
    n_compared++;
    if (o.adr !== 27'h40 || o.rwb !== 1'b1 || o.be !== 4'hF || o.en_start !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL instr_mem_req: got en=%b adr=%h rwb=%b be=%h expected 1 40 1 f",
               o.en_start, o.adr, o.rwb, o.be);
    end
    n_compared++;
    if (o.busy !== 2 || o.i_ack !== 1'b1 || o.d_ack !== 1'b0 || o.err !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL instr_ack: got busy=%0d i=%b d=%b err=%b expected 2 1 0 0",
               o.busy, o.i_ack, o.d_ack, o.err);
    end
    n_compared++;
    if (o.i_rdata !== m_i_rdata || o.ack_after !== 1'b0 || o.stable !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL instr_rdata: got %h after=%b stable=%b expected %h 0 1",
               o.i_rdata, o.ack_after, o.stable, m_i_rdata);
    end
  endtask

  task automatic test_data_write();
    obs_t o;
    d_req = 1'b1; d_we = 1'b1; d_adr = 27'h100; d_wdata = 32'hCAFEF00D; d_byteen = 4'b0011;
    run_txn(1, 32'h12345678, o);
    d_req = 1'b0; d_we = 1'b0;
    m_last_data = 1'b1;
    n_compared++;
    if (o.adr !== 27'h100 || o.rwb !== 1'b0 || o.be !== 4'b0011 || o.wdata !== 32'hCAFEF00D) begin
      n_mismatched++;
      $display("[TB] FAIL write_mem_req: got adr=%h rwb=%b be=%b wdata=%h expected 100 0 0011 cafef00d",
               o.adr, o.rwb, o.be, o.wdata);
    end
    n_compared++;
    if (o.d_ack !== 1'b1 || o.i_ack !== 1'b0 || o.busy !== 1 || o.d_rdata !== m_d_rdata) begin
      n_mismatched++;
      $display("[TB] FAIL write_ack: got d=%b i=%b busy=%0d rdata=%h expected 1 0 1 %h",
               o.d_ack, o.i_ack, o.busy, o.d_rdata, m_d_rdata);
    end
  endtask

  task automatic test_tie();
    obs_t o;
    logic exp_data;
    do_reset();
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; i_adr = 27'h0AAA; d_adr = 27'h0555;
    for (int n = 0; n < 4; n++) begin
      exp_data = ~m_last_data;
      run_txn(1, $urandom, o);
      m_last_data = exp_data;
      n_compared++;
      if (o.d_ack !== exp_data || o.i_ack !== ~exp_data ||
          o.adr !== (exp_data ? d_adr : i_adr)) begin
        n_mismatched++;
        $display("[TB] FAIL tie_rr_%0d: got d=%b i=%b adr=%h expected data=%b",
                 n, o.d_ack, o.i_ack, o.adr, exp_data);
      end
      n_compared++;
      if (o.b_d_ack !== 1'b1 || o.b_i_ack !== 1'b0) begin
        n_mismatched++;
        $display("[TB] FAIL tie_prio_%0d: got d=%b i=%b expected 1 0", n, o.b_d_ack, o.b_i_ack);
      end
      if (exp_data) m_d_rdata = o.d_rdata; else m_i_rdata = o.i_rdata;
    end
    i_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic test_timeout();
    obs_t o;
    i_req = 1'b1; i_adr = 27'h7FFFFFF;
    run_txn(0, 32'h0, o);
    i_req = 1'b0;
    m_last_data = 1'b0; m_i_rdata = 32'hDEADBEEF;
    n_compared++;
    if (o.busy !== TMO || o.hung !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL timeout_len: got busy=%0d hung=%b expected %0d 0", o.busy, o.hung, TMO);
    end
    n_compared++;
    if (o.err !== 1'b1 || o.i_ack !== 1'b1 || o.d_ack !== 1'b0 || o.i_rdata !== 32'hDEADBEEF) begin
      n_mismatched++;
      $display("[TB] FAIL timeout_resp: got err=%b i=%b d=%b rdata=%h expected 1 1 0 deadbeef",
               o.err, o.i_ack, o.d_ack, o.i_rdata);
    end
    n_compared++;
    if (o.ack_after !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL timeout_pulse: got after=%b expected 0", o.ack_after);
    end
  endtask

  task automatic test_reset_mid();
    d_req = 1'b1; d_we = 1'b0; d_adr = 27'h333;
    tick();
    tick();
    n_compared++;
    if (bus_a.mem_en !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL mid_busy: got mem_en=%b expected 1", bus_a.mem_en);
    end
    reset = 1'b1; d_req = 1'b0;
    tick();
    reset = 1'b0;
    m_last_data = 1'b0; m_i_rdata = 32'h0; m_d_rdata = 32'h0;
    n_compared++;
    if ({bus_a.mem_en, bus_a.i_ack, bus_a.d_ack, bus_a.err} !== 4'b0000) begin
      n_mismatched++;
      $display("[TB] FAIL mid_reset: got %b expected 0000",
               {bus_a.mem_en, bus_a.i_ack, bus_a.d_ack, bus_a.err});
    end
    mem_done = 1'b1; mem_rdata = 32'h55AA55AA;
    repeat (3) begin
      tick();
      n_compared++;
      if ({bus_a.mem_en, bus_a.i_ack, bus_a.d_ack, bus_a.err} !== 4'b0000 ||
          bus_a.d_rdata !== 32'h0) begin
        n_mismatched++;
        $display("[TB] FAIL mid_done_ignored: got %b rdata=%h expected 0000 0",
                 {bus_a.mem_en, bus_a.i_ack, bus_a.d_ack, bus_a.err}, bus_a.d_rdata);
      end
    end
    mem_done = 1'b0;
  endtask

  task automatic test_back_to_back();
    obs_t o;
    int prev;
    i_req = 1'b1; i_adr = 27'h1234;
    prev = -1;
    for (int n = 0; n < 3; n++) begin
      run_txn(1, 32'h1000 + n, o);
      m_last_data = 1'b0; m_i_rdata = 32'h1000 + n;
      n_compared++;
      if (o.busy !== 1 || o.i_ack !== 1'b1 || o.i_rdata !== m_i_rdata ||
          o.stable !== 1'b1 || o.adr !== 27'h1234 ||
          (prev >= 0 && o.ack_cycle - prev !== 3)) begin
        n_mismatched++;
        $display("[TB] FAIL b2b_%0d: got busy=%0d ack=%b rdata=%h stable=%b gap=%0d expected 1 1 %h 1 3",
                 n, o.busy, o.i_ack, o.i_rdata, o.stable, o.ack_cycle - prev, m_i_rdata);
      end
      prev = o.ack_cycle;
    end
    i_req = 1'b0;
  endtask

  task automatic test_random();
    obs_t o;
    logic exp_data, timed, rd;
    logic [31:0] rdv, exp_rdata;
    logic [3:0] exp_be;
    int done_at, exp_busy;
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(2, 0))
        0:       begin i_req = 1'b1; d_req = 1'b0; end
        1:       begin i_req = 1'b0; d_req = 1'b1; end
        default: begin i_req = 1'b1; d_req = 1'b1; end
      endcase
      i_adr = 27'($urandom); d_adr = 27'($urandom);
      d_we = 1'($urandom); d_wdata = $urandom; d_byteen = 4'($urandom);
      done_at = $urandom_range(10, 0);
      rdv = $urandom;
      exp_data = d_req && (!i_req || !m_last_data);
      timed    = (done_at == 0 || done_at > TMO);
      exp_busy = timed ? TMO : done_at;
      rd       = !(exp_data && d_we);
      exp_be   = rd ? 4'hF : d_byteen;
      run_txn(done_at, rdv, o);
      i_req = 1'b0; d_req = 1'b0;
      m_last_data = exp_data;
      exp_rdata = timed ? 32'hDEADBEEF : (rd ? rdv : m_d_rdata);
      if (exp_data) m_d_rdata = exp_rdata;
      else          m_i_rdata = timed ? 32'hDEADBEEF : rdv;
      n_compared++;
      if (o.adr !== (exp_data ? d_adr : i_adr) || o.rwb !== rd || o.be !== exp_be ||
          (exp_data && o.wdata !== d_wdata) || o.stable !== 1'b1) begin
        n_mismatched++;
        $display("[TB] FAIL rand_req_%0d: got adr=%h rwb=%b be=%h wdata=%h stable=%b expected data=%b rwb=%b be=%h",
                 n, o.adr, o.rwb, o.be, o.wdata, o.stable, exp_data, rd, exp_be);
      end
      n_compared++;
      if (o.busy !== exp_busy || o.err !== timed || o.d_ack !== exp_data ||
          o.i_ack !== ~exp_data || o.ack_after !== 1'b0) begin
        n_mismatched++;
        $display("[TB] FAIL rand_resp_%0d: got busy=%0d err=%b d=%b i=%b after=%b expected %0d %b %b %b 0",
                 n, o.busy, o.err, o.d_ack, o.i_ack, o.ack_after, exp_busy, timed, exp_data, ~exp_data);
      end
      n_compared++;
      if (o.i_rdata !== m_i_rdata || o.d_rdata !== m_d_rdata) begin
        n_mismatched++;
        $display("[TB] FAIL rand_rdata_%0d: got i=%h d=%h expected i=%h d=%h",
                 n, o.i_rdata, o.d_rdata, m_i_rdata, m_d_rdata);
      end
    end
  endtask

  initial begin
    test_reset();
    test_instr_read();
    test_data_write();
    test_tie();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
